regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports i_we0/i_waddr0/i_wdata0  input  1/ADDR_W/DATA_W  write port 0 (short-latency writeback).
REQ-007 SHALL have ports i_we1/i_waddr1/i_wdata1  input  1/ADDR_W/DATA_W  write port 1 (long-latency writeback; clears pending).
REQ-008 SHALL have port i_raddr  input  NRD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port o_rdata  output  NRD*DATA_W  packed read data, same packing.
REQ-010 SHALL have port o_rbusy  output  NRD  read port k addresses a register with a pending write.
REQ-011 SHALL have ports i_set_en/i_set_addr  input  1/ADDR_W  mark a register pending at issue.
REQ-012 SHALL have port o_pend_cnt  output  ADDR_W+1  number of registers currently pending.

Function
REQ-013 SHALL hardwire register 0 to zero: writes and pending-sets to address 0 are ignored; reads of address 0 return 0 and o_rbusy=0.
REQ-014 SHALL perform writes at the rising edge; port 1 wins when both ports write the same nonzero address in one cycle.
REQ-015 SHALL make read ports fully combinational and independent; any number may address the same register.
REQ-016 SHALL set pending[a] at the edge when i_set_en=1 and a!=0.
REQ-017 SHALL clear pending[a] at the edge when i_we1=1 and i_waddr1=a; port 0 writes never change pending.
REQ-018 SHALL give set priority over clear when i_set_addr equals i_waddr1 in the same cycle (register remains pending).
REQ-019 SHALL set o_rbusy[k]=pending[raddr_k], except 0 when bypass (REQ-025) is active for that port through write port 1.
REQ-020 SHALL keep o_pend_cnt equal to the population count of pending, updated in the same edge: +1 for set of a non-pending register, -1 for clear of a pending register, net 0 when both occur on different registers or per REQ-018.
REQ-021 SHALL never let o_pend_cnt wrap: range 0..2**ADDR_W-1.

Reset
REQ-022 SHALL, at an edge with reset=1, zero every register, all pending bits and o_pend_cnt; writes and sets in that cycle are discarded.
REQ-023 SHALL present after reset: o_rdata all 0, o_rbusy all 0, o_pend_cnt 0.
REQ-024 SHALL, on reset mid-operation, discard outstanding pending state; later port-1 writes to formerly pending registers only write data.

Configuration
REQ-025 With RF_BYPASS_EN defined, each read port SHALL return same-cycle write data when a write port targets its nonzero address (port 1 priority over port 0), and SHALL force o_rbusy[k]=0 when bypassed from port 1.
REQ-026 Without RF_BYPASS_EN, read ports SHALL return stored contents only; a write becomes visible the cycle after its edge and o_rbusy follows pending alone.

Structure
REQ-027 SHALL place default DATA_W/ADDR_W/NRD constants and a read-port index typedef in shared package rf_pkg.
REQ-028 SHALL implement pending bits, set/clear priority and o_pend_cnt in sub-module rf_scoreboard; storage and bypass muxing in regfile_mp.

Verification
REQ-029 Reset, then read addresses 0..31 on both ports -> all o_rdata 0, o_rbusy 00, o_pend_cnt 0.
REQ-030 Same cycle: we0 to r5=0x1111_1111 and we1 to r5=0x2222_2222 -> next cycle read r5=0x2222_2222; write 0xFFFF_FFFF to r0 -> r0 reads 0.
REQ-031 Bypass on: we0 r7=0xA5A5_A5A5 with raddr r7 same cycle -> o_rdata=0xA5A5_A5A5 that cycle; bypass off -> old value that cycle, new value next cycle.
REQ-032 set r3, set r4 -> o_pend_cnt=2, o_rbusy on r3=1; we1 r3=0x33 -> o_pend_cnt=1, r3 not busy, r3=0x33; we0 r4 -> r4 still busy.
REQ-033 Same cycle: set r9 and we1 r9=0x99 -> r9=0x99, pending, o_pend_cnt +1; set r9 again while pending -> count unchanged.
REQ-034 Set r1..r31 (cnt=31), assert reset for one edge -> cnt 0, all reads 0, we1 r1 afterwards leaves cnt 0.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional same-cycle read bypass is enabled by defining RF_BYPASS_EN.
package rf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  // Index of a read port (up to four ports).
  typedef logic [1:0] rport_idx_t;

endpackage : rf_pkg

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: two write ports, packed read ports, pending-set port.
// The master side drives writes/reads/sets; the slave side is the register file.
interface regfile_mp_if
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
);

  logic                  i_we0;
  logic [ADDR_W-1:0]     i_waddr0;
  logic [DATA_W-1:0]     i_wdata0;
  logic                  i_we1;
  logic [ADDR_W-1:0]     i_waddr1;
  logic [DATA_W-1:0]     i_wdata1;
  logic [NRD*ADDR_W-1:0] i_raddr;
  logic [NRD*DATA_W-1:0] o_rdata;
  logic [NRD-1:0]        o_rbusy;
  logic                  i_set_en;
  logic [ADDR_W-1:0]     i_set_addr;
  logic [ADDR_W:0]       o_pend_cnt;

  modport master (
    output i_we0, i_waddr0, i_wdata0,
    output i_we1, i_waddr1, i_wdata1,
    output i_raddr, i_set_en, i_set_addr,
    input  o_rdata, o_rbusy, o_pend_cnt
  );

  modport slave (
    input  i_we0, i_waddr0, i_wdata0,
    input  i_we1, i_waddr1, i_wdata1,
    input  i_raddr, i_set_en, i_set_addr,
    output o_rdata, o_rbusy, o_pend_cnt
  );

endinterface : regfile_mp_if

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared by the
// long-latency write port. Set wins over clear on the same register. Register 0
// is never marked pending. The population count is kept incrementally.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_set_en,
  input  logic [ADDR_W-1:0]      i_set_addr,
  input  logic                   i_clr_en,
  input  logic [ADDR_W-1:0]      i_clr_addr,
  output logic [(1<<ADDR_W)-1:0] o_pending,
  output logic [ADDR_W:0]        o_pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DEPTH-1:0] pend_r;
  logic [DEPTH-1:0] pend_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nxt_s;
  logic             set_v_s;
  logic             clr_v_s;
  logic             inc_s;
  logic             dec_s;

  // Next pending vector and count; set is applied after clear so it dominates.
  always_comb begin
    set_v_s    = i_set_en && (i_set_addr != {ADDR_W{1'b0}});
    clr_v_s    = i_clr_en && (i_clr_addr != {ADDR_W{1'b0}});
    pend_nxt_s = pend_r;
    if (clr_v_s) begin
      pend_nxt_s[i_clr_addr] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (set_v_s) begin
      pend_nxt_s[i_set_addr] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    inc_s = set_v_s && !pend_r[i_set_addr];
    dec_s = clr_v_s && pend_r[i_clr_addr] &&
            !(set_v_s && (i_set_addr == i_clr_addr));
    case ({inc_s, dec_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Pending bits and count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r <= {DEPTH{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign o_pending  = pend_r;
  assign o_pend_cnt = cnt_r;

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard.
// Two write ports (port 1 wins on conflict and clears pending), NRD
// combinational read ports, register 0 hardwired to zero.
// Define RF_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input logic         clk,
  input logic         reset,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_s;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (bus.i_set_en),
    .i_set_addr (bus.i_set_addr),
    .i_clr_en   (bus.i_we1),
    .i_clr_addr (bus.i_waddr1),
    .o_pending  (pend_s),
    .o_pend_cnt (bus.o_pend_cnt)
  );

  // Storage update; port 1 is applied last so it wins on an address clash.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (bus.i_we0 && (bus.i_waddr0 != {ADDR_W{1'b0}})) begin
        mem_r[bus.i_waddr0] <= bus.i_wdata0;
      end
      if (bus.i_we1 && (bus.i_waddr1 != {ADDR_W{1'b0}})) begin
        mem_r[bus.i_waddr1] <= bus.i_wdata1;
      end
    end
  end

  // Read ports: stored data and pending flag, optionally overridden by bypass.
  always_comb begin
    bus.o_rdata = {(NRD*DATA_W){1'b0}};
    bus.o_rbusy = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] raddr_v;
      logic [DATA_W-1:0] rdata_v;
      logic              busy_v;
      raddr_v = bus.i_raddr[k*ADDR_W +: ADDR_W];
      rdata_v = mem_r[raddr_v];
      busy_v  = pend_s[raddr_v];
`ifdef RF_BYPASS_EN
      if ((raddr_v != {ADDR_W{1'b0}}) && bus.i_we1 && (bus.i_waddr1 == raddr_v)) begin
        rdata_v = bus.i_wdata1;
        busy_v  = 1'b0;
      end else if ((raddr_v != {ADDR_W{1'b0}}) && bus.i_we0 && (bus.i_waddr0 == raddr_v)) begin
        rdata_v = bus.i_wdata0;
      end else begin
        rdata_v = rdata_v;
      end
`endif
      bus.o_rdata[k*DATA_W +: DATA_W] = rdata_v;
      bus.o_rbusy[k]                  = busy_v;
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, 2 read ports).
module tb_regfile_mp;
  import rf_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  regfile_mp_if ifc ();

  regfile_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifc.i_we0 = 1'b0; ifc.i_waddr0 = 5'd0; ifc.i_wdata0 = 32'd0;
    ifc.i_we1 = 1'b0; ifc.i_waddr1 = 5'd0; ifc.i_wdata1 = 32'd0;
    ifc.i_set_en = 1'b0; ifc.i_set_addr = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    ifc.i_raddr = {a1, a0};
    #1;
  endtask

  initial begin
    logic [31:0] exp_byp;
    logic [1:0]  exp_busy;
    n_cmp = 0;
    n_bad = 0;
    idle();
    ifc.i_raddr = 10'd0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Post-reset state on every address.
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 5'(31 - a));
      chk("rst_rdata", {32'd0, ifc.o_rdata}, 64'd0);
      chk("rst_rbusy", {62'd0, ifc.o_rbusy}, 64'd0);
    end
    chk("rst_cnt", {58'd0, ifc.o_pend_cnt}, 64'd0);

    // Write-port conflict: port 1 wins.
    ifc.i_we0 = 1'b1; ifc.i_waddr0 = 5'd5; ifc.i_wdata0 = 32'h1111_1111;
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd5; ifc.i_wdata1 = 32'h2222_2222;
    tick();
    idle();
    rd(5'd5, 5'd5);
    chk("conflict_r5", {32'd0, ifc.o_rdata[31:0]}, 64'h2222_2222);
    chk("conflict_r5_p1", {32'd0, ifc.o_rdata[63:32]}, 64'h2222_2222);

    // Register 0 ignores writes and sets.
    ifc.i_we0 = 1'b1; ifc.i_waddr0 = 5'd0; ifc.i_wdata0 = 32'hFFFF_FFFF;
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd0;
    tick();
    idle();
    rd(5'd0, 5'd0);
    chk("r0_zero", {32'd0, ifc.o_rdata[31:0]}, 64'd0);
    chk("r0_busy", {62'd0, ifc.o_rbusy}, 64'd0);
    chk("r0_cnt", {58'd0, ifc.o_pend_cnt}, 64'd0);

    // Same-cycle read of a register being written by port 0.
`ifdef RF_BYPASS_EN
    exp_byp = 32'hA5A5_A5A5;
`else
    exp_byp = 32'h0000_0000;
`endif
    ifc.i_we0 = 1'b1; ifc.i_waddr0 = 5'd7; ifc.i_wdata0 = 32'hA5A5_A5A5;
    rd(5'd7, 5'd7);
    chk("byp_same_cycle", {32'd0, ifc.o_rdata[31:0]}, {32'd0, exp_byp});
    tick();
    idle();
    rd(5'd7, 5'd7);
    chk("byp_next_cycle", {32'd0, ifc.o_rdata[63:32]}, 64'hA5A5_A5A5);

    // Pending set / clear through port 1; port 0 never clears.
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd3;
    tick();
    ifc.i_set_addr = 5'd4;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("pend_cnt2", {58'd0, ifc.o_pend_cnt}, 64'd2);
    chk("pend_busy34", {62'd0, ifc.o_rbusy}, 64'd3);
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd3; ifc.i_wdata1 = 32'h33;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("clr_cnt1", {58'd0, ifc.o_pend_cnt}, 64'd1);
    chk("clr_busy", {62'd0, ifc.o_rbusy}, 64'd2);
    chk("clr_r3", {32'd0, ifc.o_rdata[31:0]}, 64'h33);
    ifc.i_we0 = 1'b1; ifc.i_waddr0 = 5'd4; ifc.i_wdata0 = 32'h44;
    tick();
    idle();
    rd(5'd3, 5'd4);
    chk("we0_keeps_busy", {62'd0, ifc.o_rbusy}, 64'd2);
    chk("we0_r4", {32'd0, ifc.o_rdata[63:32]}, 64'h44);
    chk("we0_cnt", {58'd0, ifc.o_pend_cnt}, 64'd1);

    // Set wins over clear on the same register.
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd9;
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd9; ifc.i_wdata1 = 32'h99;
    tick();
    idle();
    rd(5'd9, 5'd9);
    chk("setclr_r9", {32'd0, ifc.o_rdata[31:0]}, 64'h99);
    chk("setclr_busy", {62'd0, ifc.o_rbusy}, 64'd3);
    chk("setclr_cnt", {58'd0, ifc.o_pend_cnt}, 64'd2);
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd9;
    tick();
    idle();
    #1;
    chk("reset_pending_cnt", {58'd0, ifc.o_pend_cnt}, 64'd2);

    // Set and clear on different registers: net zero (r4 cleared, r10 set).
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd10;
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd4; ifc.i_wdata1 = 32'h4040;
    tick();
    idle();
    rd(5'd4, 5'd10);
    chk("net0_cnt", {58'd0, ifc.o_pend_cnt}, 64'd2);
    chk("net0_busy", {62'd0, ifc.o_rbusy}, 64'd2);
    chk("net0_r4", {32'd0, ifc.o_rdata[31:0]}, 64'h4040);

    // Port-1 write to pending r9 while reading it.
`ifdef RF_BYPASS_EN
    exp_byp  = 32'h9A;
    exp_busy = 2'b00;
`else
    exp_byp  = 32'h99;
    exp_busy = 2'b11;
`endif
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd9; ifc.i_wdata1 = 32'h9A;
    rd(5'd9, 5'd9);
    chk("p1_byp_data", {32'd0, ifc.o_rdata[31:0]}, {32'd0, exp_byp});
    chk("p1_byp_busy", {62'd0, ifc.o_rbusy}, {62'd0, exp_busy});
    tick();
    idle();
    rd(5'd9, 5'd9);
    chk("p1_after_cnt", {58'd0, ifc.o_pend_cnt}, 64'd1);
    chk("p1_after_data", {32'd0, ifc.o_rdata[63:32]}, 64'h9A);

    // Clear of a non-pending register must not underflow.
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd2; ifc.i_wdata1 = 32'h2;
    tick();
    idle();
    #1;
    chk("no_underflow", {58'd0, ifc.o_pend_cnt}, 64'd1);

    // Fill the scoreboard, then reset mid-operation.
    for (int a = 1; a < 32; a++) begin
      ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'(a);
      tick();
    end
    idle();
    #1;
    chk("full_cnt", {58'd0, ifc.o_pend_cnt}, 64'd31);
    reset = 1'b1;
    ifc.i_set_en = 1'b1; ifc.i_set_addr = 5'd5;
    ifc.i_we0 = 1'b1; ifc.i_waddr0 = 5'd6; ifc.i_wdata0 = 32'h66;
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("mid_rst_cnt", {58'd0, ifc.o_pend_cnt}, 64'd0);
    for (int a = 0; a < 32; a += 2) begin
      rd(5'(a), 5'(a + 1));
      chk("mid_rst_rdata", {32'd0, ifc.o_rdata}, 64'd0);
      chk("mid_rst_rbusy", {62'd0, ifc.o_rbusy}, 64'd0);
    end
    ifc.i_we1 = 1'b1; ifc.i_waddr1 = 5'd1; ifc.i_wdata1 = 32'h5;
    tick();
    idle();
    rd(5'd1, 5'd6);
    chk("post_rst_cnt", {58'd0, ifc.o_pend_cnt}, 64'd0);
    chk("post_rst_r1", {32'd0, ifc.o_rdata[31:0]}, 64'h5);
    chk("post_rst_r6", {32'd0, ifc.o_rdata[63:32]}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_regfile_mp
